// File: rtl/mem_pkg.sv
// Shared types and constants for the main_memory line store.
package mem_pkg;

    localparam int LINE_W   = 128;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;

    // Controller states. RESPOND is the single completion cycle.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        RESPOND   = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    // Operation type captured at acceptance.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Latency counter width; at least one bit even when LATENCY is 1.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port line storage: synchronous write, combinational read.
// The array has no reset; its contents survive rst.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH_LINES];

    // Commit a line on the write strobe.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/main_memory.sv
// main_memory: fixed-latency 128-bit line memory behind a level request /
// one-cycle ready pulse handshake.
//
// Handshake: the initiator raises mem_read_req or mem_write_req (write wins
// if both are high) and holds it with a stable address/data until mem_ready
// pulses for one cycle, LATENCY cycles after acceptance. A new request is
// only accepted after a cycle in which both request lines are low.
//
// Optional feature: define MAIN_MEMORY_STATS_EN to add 16-bit wrapping
// rd_count / wr_count completion counters.
module main_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_write_data,
    output logic [LINE_W-1:0] mem_read_data,
    output logic              mem_ready,
`ifdef MAIN_MEMORY_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output state_t            dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    op_t               r_op;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_rdata;
    logic              r_ready;

    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_arr_idx;
    logic [LINE_W-1:0] w_arr_rdata;
    logic              w_we;
    logic              w_any_req;
    logic              w_unused_addr;

    // Line index from the byte address; offset and upper bits alias.
    assign w_req_idx     = mem_addr[OFFSET_W +: IDX_W];
    assign w_unused_addr = ^{mem_addr[ADDR_W-1:OFFSET_W+IDX_W], mem_addr[OFFSET_W-1:0]};
    assign w_any_req     = mem_read_req | mem_write_req;

    // In IDLE the array looks at the incoming index (needed for LATENCY=1);
    // otherwise it is pinned to the latched index.
    assign w_arr_idx = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_we      = (r_state == RESPOND) && (r_op == OP_WRITE);

    mem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_arr_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Request controller: accept, count down latency, respond, wait for drop.
    // mem_ready and read data are registered on entry to RESPOND so they are
    // valid for exactly the RESPOND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_READ;
            r_idx   <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_op    <= mem_write_req ? OP_WRITE : OP_READ;
                        r_idx   <= w_req_idx;
                        r_wdata <= mem_write_data;
                        if (LATENCY == 1) begin
                            r_state <= RESPOND;
                            r_ready <= 1'b1;
                            if (!mem_write_req) begin
                                r_rdata <= w_arr_rdata;
                            end
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= RESPOND;
                        r_ready <= 1'b1;
                        if (r_op == OP_READ) begin
                            r_rdata <= w_arr_rdata;
                        end
                    end
                end
                RESPOND: begin
                    r_state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!w_any_req) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MAIN_MEMORY_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Completion counters, bumped in RESPOND by op type; wrap at 0xFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == RESPOND) begin
            if (r_op == OP_WRITE) begin
                r_wr_count <= r_wr_count + 16'd1;
            end else begin
                r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign mem_read_data = r_rdata;
    assign mem_ready     = r_ready;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory (DEPTH_LINES=1024, LATENCY=4).
// Define MAIN_MEMORY_STATS_EN at build time to also exercise the counters.
module tb_main_memory;
  import mem_pkg::*;

  localparam int LATENCY     = 4;
  localparam int DEPTH_LINES = 1024;
  localparam int TIMEOUT     = 50;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst;
  logic              mem_read_req;
  logic              mem_write_req;
  logic [31:0]       mem_addr;
  logic [127:0]      mem_write_data;
  logic [127:0]      mem_read_data;
  logic              mem_ready;
  state_t            dbg_state;
`ifdef MAIN_MEMORY_STATS_EN
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  main_memory #(
    .DEPTH_LINES (DEPTH_LINES),
    .LATENCY     (LATENCY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
`ifdef MAIN_MEMORY_STATS_EN
    .rd_count       (rd_count),
    .wr_count       (wr_count),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [127:0]  exp_q[$];
  logic [127:0]  model[int];
  logic [127:0]  last_rd;
  logic [31:0]   written_q[$];

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[13:4]);
  endfunction

  // One request/response transaction. Call #1 after a posedge with the DUT idle.
  task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [127:0] data, input int hold, input string name);
    int           cyc;
    int           extra;
    logic         got;
    logic [127:0] exp;
    logic [127:0] exp_pop;
    if (wr) begin
      model[idx_of(addr)] = data;
      exp_q.push_back(last_rd);
    end else begin
      exp = model.exists(idx_of(addr)) ? model[idx_of(addr)] : '0;
      exp_q.push_back(exp);
      last_rd = exp;
    end
    mem_write_req  = wr;
    mem_read_req   = rd;
    mem_addr       = addr;
    mem_write_data = data;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) got = 1'b1;
    end
    exp_pop = exp_q.pop_front();
    n_cmp++;
    if (!got || cyc != LATENCY) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles (ready seen=%0b), expected %0d", name, cyc, got, LATENCY);
    end
    if (got) begin
      n_cmp++;
      if (mem_read_data !== exp_pop) begin
        n_fail++;
        $display("FAIL %s rdata: got %h expected %h", name, mem_read_data, exp_pop);
      end
    end
    extra = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (mem_ready) extra++;
    end
    mem_write_req = 1'b0;
    mem_read_req  = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_ready) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL %s extra_pulses: got %0d expected 0", name, extra);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s end_state: got %0d expected %0d", name, dbg_state, IDLE);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    mem_read_req = 1'b0;
    mem_write_req = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready: got %b expected 0", mem_ready);
    end
    n_cmp++;
    if (mem_read_data !== '0) begin
      n_fail++;
      $display("FAIL reset rdata: got %h expected 0", mem_read_data);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset state: got %0d expected %0d", dbg_state, IDLE);
    end
    rst = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_op(1'b1, 1'b0, 32'h0000_0040, {16{8'hA5}}, 0, "wr_a5");
    do_op(1'b0, 1'b1, 32'h0000_0040, '0, 0, "rd_a5");
    written_q.push_back(32'h0000_0040);
  endtask

  task automatic test_offset_alias();
    do_op(1'b0, 1'b1, 32'h0000_004C, '0, 0, "rd_offset");
    do_op(1'b1, 1'b0, 32'h0000_4040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, "wr_alias");
    do_op(1'b0, 1'b1, 32'h0000_0040, '0, 0, "rd_alias");
  endtask

  task automatic test_hold();
    do_op(1'b1, 1'b0, 32'h0000_0200, 128'hDEAD_BEEF, 3, "wr_hold3");
    do_op(1'b0, 1'b1, 32'h0000_0200, '0, 3, "rd_hold3");
    written_q.push_back(32'h0000_0200);
  endtask

  task automatic test_both_high();
    do_op(1'b1, 1'b1, 32'h0000_0080, 128'h1234, 0, "both_high");
    do_op(1'b0, 1'b1, 32'h0000_0080, '0, 0, "rd_after_both");
    written_q.push_back(32'h0000_0080);
  endtask

  task automatic test_reset_abort();
    int pulses;
    do_op(1'b1, 1'b0, 32'h0000_0100, 128'h5555_AAAA_0000_1111, 0, "wr_pre_abort");
    written_q.push_back(32'h0000_0100);
    mem_write_req  = 1'b1;
    mem_addr       = 32'h0000_0100;
    mem_write_data = 128'hFFFF;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    rst = 1'b1;
    mem_write_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    n_cmp++;
    if (mem_read_data !== '0) begin
      n_fail++;
      $display("FAIL abort rdata_after_rst: got %h expected 0", mem_read_data);
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort ready_pulses: got %0d expected 0", pulses);
    end
    do_op(1'b0, 1'b1, 32'h0000_0100, '0, 0, "rd_post_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0]  addr;
    logic [31:0]  base;
    logic [127:0] data;
    for (int i = 0; i < 10; i++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      if (written_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        addr = {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, 15)) << 4)
               | 32'($urandom_range(0, 15));
        do_op(1'b1, 1'b0, addr, data, $urandom_range(0, 2), "rand_wr");
        written_q.push_back(addr);
      end else begin
        base = written_q[$urandom_range(0, written_q.size() - 1)];
        addr = {16'($urandom_range(0, 65535)), 2'b00, base[13:4], 4'($urandom_range(0, 15))};
        do_op(1'b0, 1'b1, addr, '0, $urandom_range(0, 2), "rand_rd");
      end
    end
  endtask

`ifdef MAIN_MEMORY_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = '0;
    do_op(1'b1, 1'b0, 32'h0000_0300, 128'h1, 0, "st_wr1");
    do_op(1'b1, 1'b0, 32'h0000_0310, 128'h2, 0, "st_wr2");
    do_op(1'b0, 1'b1, 32'h0000_0300, '0, 0, "st_rd1");
    do_op(1'b1, 1'b0, 32'h0000_0320, 128'h3, 0, "st_wr3");
    do_op(1'b0, 1'b1, 32'h0000_0310, '0, 0, "st_rd2");
    n_cmp++;
    if (wr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stats wr_count: got %0d expected 3", wr_count);
    end
    n_cmp++;
    if (rd_count !== 16'd2) begin
      n_fail++;
      $display("FAIL stats rd_count: got %0d expected 2", rd_count);
    end
    force dut.r_wr_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_wr_count;
    do_op(1'b1, 1'b0, 32'h0000_0330, 128'h4, 0, "st_wrap");
    n_cmp++;
    if (wr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats wr_wrap: got %h expected 0", wr_count);
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_offset_alias();
    test_hold();
    test_both_high();
    test_reset_abort();
    test_back_to_back();
`ifdef MAIN_MEMORY_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter DEPTH_LINES, default 1024, sets the number of 128-bit lines stored (power of two, >=2).
REQ-002 Parameter LATENCY, default 4, sets cycles from request acceptance to mem_ready (>=1).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_read_req  input  1  line read request, level, held by the initiator until mem_ready.
REQ-006 mem_write_req  input  1  line write request, level, held by the initiator until mem_ready.
REQ-007 mem_addr  input  32  byte address; bits [3:0] ignored, line index = mem_addr[4+IDX_W-1:4], IDX_W = log2(DEPTH_LINES), upper bits ignored (aliasing).
REQ-008 mem_write_data  input  128  line to store on a write.
REQ-009 mem_read_data  output  128  registered line returned on a read.
REQ-010 mem_ready  output  1  registered one-cycle completion pulse.

Function
REQ-011 FSM states: IDLE, BUSY, RESPOND, WAIT_DROP.
REQ-012 IDLE: if either request is high, latch op, index and write data, load latency counter with LATENCY-1, go BUSY (LATENCY=1: go RESPOND directly).
REQ-013 Both requests high in the same IDLE cycle: accept as write; read ignored.
REQ-014 BUSY: decrement counter each cycle; at zero go RESPOND; request inputs and address changes ignored while BUSY.
REQ-015 RESPOND: mem_ready=1 for exactly this cycle; write commits latched data to latched index in this cycle; read drives mem_read_data with the line at latched index in this cycle.
REQ-016 Acceptance at cycle t yields mem_ready high during cycle t+LATENCY.
REQ-017 After RESPOND go WAIT_DROP; stay until both requests are low, then IDLE; no new request accepted before a cycle with both requests low.
REQ-018 mem_read_data holds its value except when updated in RESPOND of a read; writes never change it.
REQ-019 Read after write to the same index returns the written line.
REQ-020 Array contents undefined at power-up; simulation model initialises to all zeros.

Reset
REQ-021 rst: state=IDLE, mem_ready=0, mem_read_data=0, counter=0, latched op/index/data cleared.
REQ-022 rst does not clear the array.
REQ-023 rst asserted while BUSY aborts the op; no array write occurs; no mem_ready is produced.

Configuration
REQ-024 Macro MAIN_MEMORY_STATS_EN defined: adds outputs rd_count and wr_count (16 bits each, reset 0), each incremented in RESPOND of its op type, wrapping at 0xFFFF to 0.
REQ-025 MAIN_MEMORY_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-026 Package mem_pkg holds LINE_W=128, ADDR_W=32, OFFSET_W=4 and the state enum type.
REQ-027 Storage in sub-module mem_array: single-port RAM, DEPTH_LINES x 128, synchronous write, combinational read.
REQ-028 Counter width derived from LATENCY; no other sub-modules.

Verification
REQ-029 LATENCY=4: write 0xA5..A5 at 0x0000_0040 held high -> mem_ready single pulse 4 cycles after acceptance; then read 0x0000_0040 -> mem_read_data=0xA5..A5 with mem_ready.
REQ-030 Read 0x0000_004C after write to 0x0000_0040 -> same line returned (offset ignored); with DEPTH_LINES=1024, write 0x0000_4040 -> aliases to index 4.
REQ-031 Request kept high 3 cycles after mem_ready -> exactly one mem_ready pulse; next request accepted only after both requests low for a cycle.
REQ-032 Read and write both high, addr 0x80, data 0x1234 -> write performed, mem_read_data unchanged; subsequent read of 0x80 returns 0x1234.
REQ-033 rst pulsed 2 cycles into a write of 0xFFFF to 0x100 -> no mem_ready, later read of 0x100 returns previous contents; mem_read_data=0 after rst.
REQ-034 MAIN_MEMORY_STATS_EN: 3 writes, 2 reads -> wr_count=3, rd_count=2; preload wr_count=0xFFFF then one write -> 0.
